// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
//   instruction-fetch path (read-only) and the load/store path (read/write).
// Latency: a request sampled in IDLE gives gnt + mem_en the next cycle (ACCESS).
//   Read data appears with a one-cycle rvalid MEM_LAT+1 cycles after ACCESS.
// Backpressure: one transaction in flight. A request raised while busy is held
//   by its requester until the arbiter returns to IDLE.
//
// Optional feature: define ROUND_ROBIN_EN for an alternating tie-break.
//   Without it, data always wins a tie.
//
// Ports:
//   clk, reset (async, active low)
//   f_req/f_addr -> f_gnt, f_rvalid, f_rdata             fetch requester (reads only)
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata  load/store requester
//   mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
//   busy (state != IDLE), owner (0 = fetch, 1 = data; valid while busy)
// All outputs are registered.
module mem_port_arbiter #(
   parameter int AW      = 8,
   parameter int DW      = 16,
   parameter int MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);

   localparam int            CW        = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] LAT_LOAD  = CW'(MEM_LAT);
   localparam logic [CW-1:0] LAST_WAIT = CW'(1);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          owner_q;
   logic          busy_q;
   logic          mem_en_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic          f_gnt_q;
   logic          d_gnt_q;
   logic          f_rvalid_q;
   logic          d_rvalid_q;
   logic [DW-1:0] f_rdata_q;
   logic [DW-1:0] d_rdata_q;

   // Winner of this cycle's arbitration: 1 = data, 0 = fetch.
   // Only consumed in IDLE when at least one request is high.
   logic owner_d;

`ifdef ROUND_ROBIN_EN
   // Last tie winner (0 = fetch, 1 = data). The reset value of "fetch" hands
   // the first tie to data.
   logic last_tie_q;
   assign owner_d = d_req & (~f_req | ~last_tie_q);
`else
   // Data always wins when it asks, so the current instruction can finish.
   assign owner_d = d_req;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         owner_q     <= 1'b0;
         busy_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         f_gnt_q     <= 1'b0;
         d_gnt_q     <= 1'b0;
         f_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         f_rdata_q   <= '0;
         d_rdata_q   <= '0;
`ifdef ROUND_ROBIN_EN
         last_tie_q  <= 1'b0;
`endif
      end else begin
         // Strobes are single-cycle, and the memory bus is zero outside ACCESS.
         f_gnt_q     <= 1'b0;
         d_gnt_q     <= 1'b0;
         f_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;

         case (state_q)
            IDLE: begin
               if (f_req | d_req) begin
                  // The request is committed here. The mem_* registers hold
                  // the latched transaction for the single ACCESS cycle.
                  state_q     <= ACCESS;
                  busy_q      <= 1'b1;
                  owner_q     <= owner_d;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= owner_d & d_we;
                  mem_addr_q  <= owner_d ? d_addr : f_addr;
                  mem_wdata_q <= owner_d ? d_wdata : '0;
                  f_gnt_q     <= ~owner_d;
                  d_gnt_q     <= owner_d;
`ifdef ROUND_ROBIN_EN
                  if (f_req & d_req) begin
                     last_tie_q <= owner_d;
                  end
`endif
               end
            end
            ACCESS: begin
               if (mem_we_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= WAIT;
                  cnt_q   <= LAT_LOAD;
               end
            end
            WAIT: begin
               // mem_rdata is valid MEM_LAT cycles after mem_en, which is the
               // last WAIT cycle.
               if (cnt_q == LAST_WAIT) begin
                  state_q <= RESP;
                  if (owner_q) begin
                     d_rdata_q  <= mem_rdata;
                     d_rvalid_q <= 1'b1;
                  end else begin
                     f_rdata_q  <= mem_rdata;
                     f_rvalid_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign f_gnt     = f_gnt_q;
   assign d_gnt     = d_gnt_q;
   assign f_rvalid  = f_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign f_rdata   = f_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign owner     = owner_q;

endmodule
